// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the dcache coherence agent.
//   cc_req_t       : request kinds the cache core hands to the agent
//   agent_state_t  : agent FSM states
//   BLK_OFF        : first block-address bit (2-word, 8-byte blocks)
//   WORD_SEL       : address bit that selects the word inside a block
//   blk_word_addr  : builds a bus word address from a block address and word index
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        CC_FILL  = 2'd0,
        CC_FILLX = 2'd1,
        CC_WB    = 2'd2,
        CC_UPG   = 2'd3
    } cc_req_t;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SNP_CHK  = 4'd1,
        SNP_SUP0 = 4'd2,
        SNP_SUP1 = 4'd3,
        SNP_END  = 4'd4,
        FILL0    = 4'd5,
        FILL1    = 4'd6,
        WB0      = 4'd7,
        WB1      = 4'd8,
        UPG      = 4'd9,
        DONE     = 4'd10
    } agent_state_t;

    localparam int BLK_OFF  = 3;
    localparam int WORD_SEL = 2;

    function automatic logic [31:0] blk_word_addr(input logic [31:BLK_OFF] blk,
                                                  input logic             w);
        logic [31:0] a;
        a                = '0;
        a[31:BLK_OFF]    = blk;
        a[WORD_SEL]      = w;
        return a;
    endfunction

endpackage

// File: rtl/cc_word_seq.sv
// ----------------------------------------------------------------------------
// cc_word_seq
// Two-word beat sequencer shared by the fill, writeback and snoop-supply paths.
// Captures the block address on start_i, then toggles the word index on every
// accepted beat and presents the matching bus word address.
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   start_i     load base_i and restart at word 0
//   base_i      full request/snoop address (low bits ignored for daddr_o)
//   adv_i       current beat accepted on the bus
//   word_o      current word index (0/1)
//   base_o      captured address, unmodified
//   daddr_o     {base[31:3], word, 2'b00}
// ----------------------------------------------------------------------------
module cc_word_seq
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start_i,
    input  logic [31:0] base_i,
    input  logic        adv_i,
    output logic        word_o,
    output logic [31:0] base_o,
    output logic [31:0] daddr_o
);

    logic        word_q;
    logic [31:0] base_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            word_q <= 1'b0;
            base_q <= '0;
        end else if (start_i) begin
            word_q <= 1'b0;
            base_q <= base_i;
        end else if (adv_i) begin
            // wraps back to 0 after the second beat
            word_q <= ~word_q;
        end
    end

    assign word_o  = word_q;
    assign base_o  = base_q;
    assign daddr_o = blk_word_addr(base_q[31:BLK_OFF], word_q);

endmodule

// File: rtl/dcache_coherence_agent.sv
// ----------------------------------------------------------------------------
// dcache_coherence_agent
// Cache-side endpoint of the coherence bus. Issues 2-word fills (plain or
// exclusive), dirty writebacks and S->M upgrade broadcasts for the local
// dcache, and serves snoops from the memory controller: supplies dirty blocks,
// invalidates or downgrades local lines.
// Configuration macro: COH_AGENT_STATS_EN adds saturating snoop_cnt,
// supply_cnt and inv_cnt outputs; without it they do not exist.
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   req_valid/req_type/req_addr       core request, held until req_done
//   wb_data0/1                        writeback words
//   req_done, fill_data0/1            completion pulse and filled words
//   dREN, dWEN, daddr, dstore         bus request, word address, write/supply data
//   ccwrite, cctrans                  exclusive/upgrade flag, snoop-supply reply
//   dwait, dload                      bus handshake and read data
//   ccwait, ccinv, ccsnoopaddr        snoop request from the controller
//   snp_addr, snp_hit, snp_dirty,
//   snp_data0/1                       tag lookup into the local array
//   snp_inv, snp_dgrade               line invalidate / M->S pulses
// ----------------------------------------------------------------------------
module dcache_coherence_agent
    import cpu_types_pkg::*;
#(
    parameter int UPG_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] wb_data0,
    input  logic [31:0] wb_data1,
    output logic        req_done,
    output logic [31:0] fill_data0,
    output logic [31:0] fill_data1,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        ccwrite,
    output logic        cctrans,
    input  logic        dwait,
    input  logic [31:0] dload,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic [31:0] snp_addr,
    input  logic        snp_hit,
    input  logic        snp_dirty,
    input  logic [31:0] snp_data0,
    input  logic [31:0] snp_data1,
    output logic        snp_inv,
    output logic        snp_dgrade
`ifdef COH_AGENT_STATS_EN
    ,
    output logic [31:0] snoop_cnt,
    output logic [31:0] supply_cnt,
    output logic [31:0] inv_cnt
`endif
);

    localparam logic [2:0] UPG_LAST = 3'(UPG_CYCLES - 1);

    agent_state_t state_q;
    logic [2:0]   upg_cnt_q;
    logic         fillx_q;
    logic         snp_inv_q;
    logic         snp_dgrade_q;
    logic [31:0]  fill_data0_q;
    logic [31:0]  fill_data1_q;
    logic [31:0]  snp_addr_q;
    logic [31:0]  wb0_q, wb1_q;
    logic [31:0]  sup0_q, sup1_q;

    logic         req_accept;
    logic         snp_accept;
    logic         beat_state;
    logic         own_busy;
    logic         seq_start;
    logic [31:0]  seq_base_in;
    logic         seq_adv;
    logic         seq_word;
    logic [31:0]  seq_base;
    logic [31:0]  seq_daddr;

    // A pending snoop always wins over the core's own request.
    assign snp_accept = (state_q == IDLE) && ccwait;
    assign req_accept = (state_q == IDLE) && !ccwait && req_valid;

    assign beat_state = (state_q == FILL0) || (state_q == FILL1) ||
                        (state_q == WB0)   || (state_q == WB1)   ||
                        (state_q == SNP_SUP0) || (state_q == SNP_SUP1);
    assign own_busy   = (state_q == FILL0) || (state_q == FILL1) ||
                        (state_q == WB0)   || (state_q == WB1)   ||
                        (state_q == UPG);

    assign seq_start   = snp_accept || req_accept;
    assign seq_base_in = ccwait ? ccsnoopaddr : req_addr;
    assign seq_adv     = beat_state && !dwait;

    cc_word_seq u_seq (
        .CLK     (CLK),
        .nRST    (nRST),
        .start_i (seq_start),
        .base_i  (seq_base_in),
        .adv_i   (seq_adv),
        .word_o  (seq_word),
        .base_o  (seq_base),
        .daddr_o (seq_daddr)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            upg_cnt_q    <= '0;
            fillx_q      <= 1'b0;
            snp_inv_q    <= 1'b0;
            snp_dgrade_q <= 1'b0;
            fill_data0_q <= '0;
            fill_data1_q <= '0;
            snp_addr_q   <= '0;
        end else begin
            snp_inv_q    <= 1'b0;
            snp_dgrade_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (snp_accept) begin
                        snp_addr_q <= ccsnoopaddr;
                        state_q    <= SNP_CHK;
                    end else if (req_accept) begin
                        fillx_q   <= (cc_req_t'(req_type) == CC_FILLX);
                        upg_cnt_q <= '0;
                        case (cc_req_t'(req_type))
                            CC_FILL, CC_FILLX: state_q <= FILL0;
                            CC_WB:             state_q <= WB0;
                            default:           state_q <= UPG;
                        endcase
                    end
                end
                SNP_CHK: begin
                    if (snp_hit && snp_dirty) begin
                        state_q <= SNP_SUP0;
                    end else begin
                        snp_inv_q <= ccinv && snp_hit;
                        state_q   <= SNP_END;
                    end
                end
                SNP_SUP0: if (!dwait) state_q <= SNP_SUP1;
                SNP_SUP1: begin
                    if (!dwait) begin
                        snp_inv_q    <= ccinv;
                        snp_dgrade_q <= !ccinv;
                        state_q      <= SNP_END;
                    end
                end
                SNP_END: if (!ccwait) state_q <= IDLE;
                FILL0: begin
                    if (!dwait) begin
                        fill_data0_q <= dload;
                        state_q      <= FILL1;
                    end
                end
                FILL1: begin
                    if (!dwait) begin
                        fill_data1_q <= dload;
                        state_q      <= DONE;
                    end
                end
                WB0: if (!dwait) state_q <= WB1;
                WB1: if (!dwait) state_q <= DONE;
                UPG: begin
                    if (upg_cnt_q == UPG_LAST) begin
                        state_q <= DONE;
                    end else begin
                        upg_cnt_q <= upg_cnt_q + 3'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Word buffers: only ever read in states that loaded them first.
    always_ff @(posedge CLK) begin
        if (req_accept) begin
            wb0_q <= wb_data0;
            wb1_q <= wb_data1;
        end
        if (state_q == SNP_CHK) begin
            sup0_q <= snp_data0;
            sup1_q <= snp_data1;
        end
    end

    // Bus outputs decoded from registered state only.
    always_comb begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        ccwrite = 1'b0;
        cctrans = 1'b0;
        daddr   = '0;
        dstore  = '0;
        case (state_q)
            FILL0, FILL1: begin
                dREN    = 1'b1;
                ccwrite = fillx_q;
                daddr   = seq_daddr;
            end
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = seq_daddr;
                dstore = seq_word ? wb1_q : wb0_q;
            end
            SNP_SUP0, SNP_SUP1: begin
                cctrans = 1'b1;
                daddr   = seq_daddr;
                dstore  = seq_word ? sup1_q : sup0_q;
            end
            UPG: begin
                ccwrite = 1'b1;
                daddr   = seq_base;
            end
            default: ;
        endcase
    end

    assign req_done   = (state_q == DONE);
    assign fill_data0 = fill_data0_q;
    assign fill_data1 = fill_data1_q;
    assign snp_addr   = snp_addr_q;
    assign snp_inv    = snp_inv_q;
    assign snp_dgrade = snp_dgrade_q;

`ifdef COH_AGENT_STATS_EN
    logic [31:0] snoop_cnt_q, supply_cnt_q, inv_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            snoop_cnt_q  <= '0;
            supply_cnt_q <= '0;
            inv_cnt_q    <= '0;
        end else begin
            if (snp_accept)                         snoop_cnt_q  <= sat_inc(snoop_cnt_q);
            if ((state_q == SNP_SUP1) && !dwait)    supply_cnt_q <= sat_inc(supply_cnt_q);
            if (snp_inv_q)                          inv_cnt_q    <= sat_inc(inv_cnt_q);
        end
    end

    assign snoop_cnt  = snoop_cnt_q;
    assign supply_cnt = supply_cnt_q;
    assign inv_cnt    = inv_cnt_q;
`endif

    // Controller must not start a snoop while this cache owns the bus.
    a_no_snoop_while_busy: assert property (@(posedge CLK) disable iff (!nRST)
        own_busy |-> !$rose(ccwait));

    // Core must hold its request until req_done.
    a_req_held: assert property (@(posedge CLK) disable iff (!nRST)
        own_busy |-> req_valid);

endmodule

// File: tb/tb_dcache_coherence_agent.sv
module tb_dcache_coherence_agent;

    localparam int UPG_CYCLES = 2;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_SUP  = 2;
    localparam int K_UPG  = 3;
    localparam int K_DONE = 4;
    localparam int K_INV  = 5;
    localparam int K_DGR  = 6;

    logic        CLK, nRST;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [31:0] req_addr, wb_data0, wb_data1;
    logic        req_done;
    logic [31:0] fill_data0, fill_data1;
    logic        dREN, dWEN, ccwrite, cctrans;
    logic [31:0] daddr, dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ccwait, ccinv;
    logic [31:0] ccsnoopaddr, snp_addr;
    logic        snp_hit, snp_dirty;
    logic [31:0] snp_data0, snp_data1;
    logic        snp_inv, snp_dgrade;
`ifdef COH_AGENT_STATS_EN
    logic [31:0] snoop_cnt, supply_cnt, inv_cnt;
`endif

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_f0  = '0;
    logic [31:0] last_f1  = '0;

    dcache_coherence_agent #(.UPG_CYCLES(UPG_CYCLES)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_valid  (req_valid),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .wb_data0   (wb_data0),
        .wb_data1   (wb_data1),
        .req_done   (req_done),
        .fill_data0 (fill_data0),
        .fill_data1 (fill_data1),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .ccwrite    (ccwrite),
        .cctrans    (cctrans),
        .dwait      (dwait),
        .dload      (dload),
        .ccwait     (ccwait),
        .ccinv      (ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .snp_addr   (snp_addr),
        .snp_hit    (snp_hit),
        .snp_dirty  (snp_dirty),
        .snp_data0  (snp_data0),
        .snp_data1  (snp_data1),
        .snp_inv    (snp_inv),
        .snp_dgrade (snp_dgrade)
`ifdef COH_AGENT_STATS_EN
        ,
        .snoop_cnt  (snoop_cnt),
        .supply_cnt (supply_cnt),
        .inv_cnt    (inv_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory contents as seen by fills; two words fixed for the directed case.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_AAAA;
        if (a == 32'h104) return 32'h0000_BBBB;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb dload = mem_word(daddr);

    // Memory side: random wait states.
    initial begin
        dwait = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            dwait = ($urandom_range(0, 3) == 0);
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_RD:    return "bus_read";
            K_WR:    return "bus_write";
            K_SUP:   return "snoop_supply";
            K_UPG:   return "upgrade";
            K_DONE:  return "req_done";
            K_INV:   return "snp_inv";
            default: return "snp_dgrade";
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.k = k;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic see(input int k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected %s: got a=%h b=%h, required no event", kname(k), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || e.a != a || e.b != b) begin
                n_fail++;
                $display("FAIL %s: got %s a=%h b=%h, required %s a=%h b=%h",
                         kname(e.k), kname(k), a, b, kname(e.k), e.a, e.b);
            end
        end
    endtask

    // Monitor: turns DUT activity into events and checks them against the queue.
    initial begin : monitor
        int          run;
        logic [31:0] run_addr;
        run      = 0;
        run_addr = '0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                run = 0;
            end else begin
                n_checks++;
                if ((dREN && dWEN) || (cctrans && (dREN || dWEN)) || (ccwrite && dWEN)) begin
                    n_fail++;
                    $display("FAIL bus_exclusive: got dREN=%b dWEN=%b cctrans=%b ccwrite=%b, required at most one",
                             dREN, dWEN, cctrans, ccwrite);
                end
                if (dREN && !dwait)    see(K_RD, daddr, {31'd0, ccwrite});
                if (dWEN && !dwait)    see(K_WR, daddr, dstore);
                if (cctrans && !dwait) see(K_SUP, daddr, dstore);
                if (ccwrite && !dREN) begin
                    run++;
                    run_addr = daddr;
                end else if (run != 0) begin
                    see(K_UPG, run_addr, 32'(run));
                    run = 0;
                end
                if (req_done)   see(K_DONE, fill_data0, fill_data1);
                if (snp_inv)    see(K_INV, snp_addr, 32'd0);
                if (snp_dgrade) see(K_DGR, snp_addr, 32'd0);
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        logic [31:0] any;
        any = fill_data0 | fill_data1 | daddr | dstore | snp_addr |
              {25'd0, req_done, dREN, dWEN, ccwrite, cctrans, snp_inv, snp_dgrade};
        n_checks++;
        if (any != 32'd0) begin
            n_fail++;
            $display("FAIL %s: got outputs OR=%h done=%b dREN=%b dWEN=%b ccwrite=%b cctrans=%b, required all zero",
                     name, any, req_done, dREN, dWEN, ccwrite, cctrans);
        end
    endtask

    task automatic wait_q_le(input int n);
        int t;
        t = 0;
        while (exp_q.size() > n && t < 300) begin
            @(posedge CLK);
            #1;
            t++;
        end
        n_checks++;
        if (exp_q.size() > n) begin
            n_fail++;
            $display("FAIL snoop_timeout: got %0d pending events, required %0d", exp_q.size(), n);
        end
    endtask

    // One transaction: optional snoop and/or optional core request, launched together.
    task automatic op(input bit ds, input logic [31:0] sa, input bit si, input bit sh, input bit sd,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input bit dr, input logic [1:0] rt, input logic [31:0] ra,
                      input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] sblk, rblk;
        int          nreq;
        int          t;
        sblk = sa & 32'hFFFF_FFF8;
        rblk = ra & 32'hFFFF_FFF8;
        nreq = 0;
        if (ds) begin
            if (sh && sd) begin
                push(K_SUP, sblk, d0);
                push(K_SUP, sblk | 32'h4, d1);
                push(si ? K_INV : K_DGR, sa, 32'd0);
            end else if (si && sh) begin
                push(K_INV, sa, 32'd0);
            end
        end
        if (dr) begin
            case (rt)
                2'd0, 2'd1: begin
                    push(K_RD, rblk, {31'd0, (rt == 2'd1)});
                    push(K_RD, rblk | 32'h4, {31'd0, (rt == 2'd1)});
                    last_f0 = mem_word(rblk);
                    last_f1 = mem_word(rblk | 32'h4);
                    nreq = 3;
                end
                2'd2: begin
                    push(K_WR, rblk, w0);
                    push(K_WR, rblk | 32'h4, w1);
                    nreq = 3;
                end
                default: begin
                    push(K_UPG, ra, 32'(UPG_CYCLES));
                    nreq = 2;
                end
            endcase
            push(K_DONE, last_f0, last_f1);
        end
        @(posedge CLK);
        #1;
        if (ds) begin
            ccsnoopaddr = sa;
            ccinv       = si;
            snp_hit     = sh;
            snp_dirty   = sd;
            snp_data0   = d0;
            snp_data1   = d1;
            ccwait      = 1'b1;
        end
        if (dr) begin
            req_type  = rt;
            req_addr  = ra;
            wb_data0  = w0;
            wb_data1  = w1;
            req_valid = 1'b1;
        end
        if (ds) begin
            wait_q_le(nreq);
            repeat (3) begin
                @(posedge CLK);
                #1;
            end
            ccwait = 1'b0;
        end
        if (dr) begin
            t = 0;
            while (!req_done && t < 300) begin
                @(posedge CLK);
                #1;
                t++;
            end
            n_checks++;
            if (!req_done) begin
                n_fail++;
                $display("FAIL req_timeout: got req_done=%b, required 1", req_done);
            end
            req_valid = 1'b0;
        end
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Reset asserted while the second fill beat is outstanding.
    task automatic reset_mid_fill(input logic [31:0] ra);
        int t;
        push(K_RD, ra, 32'd0);
        @(posedge CLK);
        #1;
        req_type  = 2'd0;
        req_addr  = ra;
        req_valid = 1'b1;
        t = 0;
        while (!(dREN && daddr[2]) && t < 300) begin
            @(posedge CLK);
            #1;
            t++;
        end
        n_checks++;
        if (!(dREN && daddr[2])) begin
            n_fail++;
            $display("FAIL fill1_timeout: got dREN=%b daddr=%h, required second beat", dREN, daddr);
        end
        nRST = 1'b0;
        #1;
        check_idle_outputs("reset_mid_fill_async");
        req_valid = 1'b0;
        last_f0   = '0;
        last_f1   = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle_outputs("reset_mid_fill_held");
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_abort: got %0d pending events, required 0", exp_q.size());
        end
        nRST = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        nRST        = 1'b0;
        req_valid   = 1'b0;
        req_type    = 2'd0;
        req_addr    = '0;
        wb_data0    = '0;
        wb_data1    = '0;
        ccwait      = 1'b0;
        ccinv       = 1'b0;
        ccsnoopaddr = '0;
        snp_hit     = 1'b0;
        snp_dirty   = 1'b0;
        snp_data0   = '0;
        snp_data1   = '0;

        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset_state");
        nRST = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        check_idle_outputs("idle_after_reset");

        //  ds  sa             si sh sd d0     d1      dr rt    ra             w0     w1
        op(0, 32'h0,          0, 0, 0, 32'h0, 32'h0,  1, 2'd0, 32'h100,       32'h0, 32'h0);
        op(0, 32'h0,          0, 0, 0, 32'h0, 32'h0,  1, 2'd1, 32'h200,       32'h0, 32'h0);
        op(0, 32'h0,          0, 0, 0, 32'h0, 32'h0,  1, 2'd2, 32'h300,       32'h11, 32'h22);
        op(0, 32'h0,          0, 0, 0, 32'h0, 32'h0,  1, 2'd3, 32'h500,       32'h0, 32'h0);
        op(1, 32'h400,        0, 1, 1, 32'h5, 32'h6,  0, 2'd0, 32'h0,         32'h0, 32'h0);
        op(1, 32'h440,        1, 1, 0, 32'h7, 32'h8,  0, 2'd0, 32'h0,         32'h0, 32'h0);
        op(1, 32'h480,        1, 0, 0, 32'h9, 32'hA,  0, 2'd0, 32'h0,         32'h0, 32'h0);
        op(1, 32'h4C4,        1, 1, 1, 32'h33, 32'h44, 1, 2'd0, 32'h706,      32'h0, 32'h0);
        reset_mid_fill(32'h600);
        op(0, 32'h0,          0, 0, 0, 32'h0, 32'h0,  1, 2'd2, 32'h808,       32'h55, 32'h66);

        for (int i = 0; i < 48; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            op(kind != 0, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom(), $urandom(),
               kind != 1, 2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom());
        end

        repeat (4) @(posedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
